// File: rtl/tdm_frame_sequencer_if.sv
// Bundle of the codec-side serial pins and the core-side sample bus of the
// TDM128 frame sequencer. The sequencer uses the master view; the codec/core
// environment uses the slave view.
interface tdm_frame_sequencer_if #(
  parameter int W = 16
);
  // Codec serial link
  logic                sdin;
  logic                bick;
  logic                lrck;
  logic                sdout;
  // Core sample bus
  logic signed [W-1:0] dac0;
  logic signed [W-1:0] dac1;
  logic signed [W-1:0] dac2;
  logic signed [W-1:0] dac3;
  logic                mute;
  logic signed [W-1:0] adc0;
  logic signed [W-1:0] adc1;
  logic signed [W-1:0] adc2;
  logic signed [W-1:0] adc3;
  logic                adc_valid;
  logic                running;

  modport master (
    input  sdin, dac0, dac1, dac2, dac3, mute,
    output bick, lrck, sdout, adc0, adc1, adc2, adc3, adc_valid, running
  );

  modport slave (
    output sdin, dac0, dac1, dac2, dac3, mute,
    input  bick, lrck, sdout, adc0, adc1, adc2, adc3, adc_valid, running
  );
endinterface

// File: rtl/tdm_frame_sequencer.sv
// 4-channel TDM128 frame sequencer running from the 256*fs system clock.
// A free-running 8-bit counter spans one frame: bit index b = cnt[7:1],
// slot = b[6:5], pos = b[4:0]. Samples sit MSB-first in the top W bits of each
// 32-bit slot with no one-bit delay. DAC output is held at zero for the first
// MUTE_FRAMES frames after reset and whenever mute was latched at a frame edge.
module tdm_frame_sequencer #(
  parameter int W           = 16,
  parameter int MUTE_FRAMES = 16
) (
  input  logic                  clk_256fs,
  input  logic                  rst,
  tdm_frame_sequencer_if.master tdm
);

  typedef enum logic [0:0] {
    ST_MUTE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Bit of a slot word sent/received at slot position pos (0 in the padding).
  function automatic logic slot_bit(input logic [W-1:0] word, input logic [4:0] pos);
    logic [W-1:0] shifted;
    logic         result;
    if (int'(pos) < W) begin
      shifted = word >> (W - 1 - int'(pos));
      result  = shifted[0];
    end else begin
      shifted = {W{1'b0}};
      result  = 1'b0;
    end
    return result;
  endfunction

  // Word with the bit at slot position pos replaced; padding positions ignored.
  function automatic logic [W-1:0] place_bit(input logic [W-1:0] word,
                                             input logic [4:0]   pos,
                                             input logic         value);
    logic [W-1:0] mask;
    logic [W-1:0] result;
    if (int'(pos) < W) begin
      mask   = W'(1'b1) << (W - 1 - int'(pos));
      result = value ? (word | mask) : (word & ~mask);
    end else begin
      mask   = {W{1'b0}};
      result = word;
    end
    return result;
  endfunction

  state_t            state_r;
  logic [7:0]        cnt_r;
  logic [7:0]        frame_cnt_r;
  logic [3:0][W-1:0] shadow_r;
  logic [3:0][W-1:0] asm_r;
  logic [3:0][W-1:0] adc_r;
  logic              mute_q_r;
  logic              bick_r;
  logic              lrck_r;
  logic              sdout_r;
  logic              adc_valid_r;
  logic              running_r;

  logic [7:0]        cnt_nxt_s;
  logic [6:0]        b_cur_s;
  logic [6:0]        b_nxt_s;
  logic              frame_end_s;
  logic              enter_run_s;
  logic              run_nxt_s;
  logic [3:0][W-1:0] shadow_nxt_s;
  logic              mute_q_nxt_s;
  logic              sdout_nxt_s;
  logic [3:0][W-1:0] asm_nxt_s;

  // Next-cycle view of counter, shadow, mute latch and RUN flag; the serial
  // bit for the coming bit period is taken from that view so slot 0's MSB is
  // already on the pin in the first cycle of the frame.
  always_comb begin
    cnt_nxt_s   = cnt_r + 8'd1;
    b_cur_s     = cnt_r[7:1];
    b_nxt_s     = cnt_nxt_s[7:1];
    frame_end_s = (cnt_r == 8'd255);

    if (frame_end_s) begin
      shadow_nxt_s = {tdm.dac3, tdm.dac2, tdm.dac1, tdm.dac0};
      mute_q_nxt_s = tdm.mute;
    end else begin
      shadow_nxt_s = shadow_r;
      mute_q_nxt_s = mute_q_r;
    end

    enter_run_s = (state_r == ST_MUTE) && frame_end_s &&
                  (frame_cnt_r == 8'(MUTE_FRAMES - 1));
    run_nxt_s   = (state_r == ST_RUN) || enter_run_s;

    if (run_nxt_s && !mute_q_nxt_s) begin
      sdout_nxt_s = slot_bit(shadow_nxt_s[b_nxt_s[6:5]], b_nxt_s[4:0]);
    end else begin
      sdout_nxt_s = 1'b0;
    end

    asm_nxt_s = asm_r;
    if (cnt_r[0]) begin
      asm_nxt_s[b_cur_s[6:5]] = place_bit(asm_r[b_cur_s[6:5]], b_cur_s[4:0], tdm.sdin);
    end else begin
      asm_nxt_s = asm_r;
    end
  end

  // Frame timing, mute/run state machine, DAC serialiser and ADC deserialiser.
  always_ff @(posedge clk_256fs) begin
    if (rst) begin
      state_r     <= ST_MUTE;
      cnt_r       <= 8'd0;
      frame_cnt_r <= 8'd0;
      shadow_r    <= {(4 * W){1'b0}};
      asm_r       <= {(4 * W){1'b0}};
      adc_r       <= {(4 * W){1'b0}};
      mute_q_r    <= 1'b0;
      bick_r      <= 1'b0;
      lrck_r      <= 1'b1;
      sdout_r     <= 1'b0;
      adc_valid_r <= 1'b0;
      running_r   <= 1'b0;
    end else begin
      cnt_r    <= cnt_nxt_s;
      bick_r   <= cnt_nxt_s[0];
      lrck_r   <= ~cnt_nxt_s[7];
      shadow_r <= shadow_nxt_s;
      mute_q_r <= mute_q_nxt_s;
      asm_r    <= asm_nxt_s;
      if (cnt_r[0]) begin
        sdout_r <= sdout_nxt_s;
      end
      if (frame_end_s) begin
        adc_r <= asm_nxt_s;
      end
      // Uses the pre-transition state, so the frame that ends the mute
      // period raises no pulse.
      adc_valid_r <= frame_end_s && (state_r == ST_RUN);
      running_r   <= run_nxt_s;
      case (state_r)
        ST_MUTE: begin
          if (frame_end_s) begin
            frame_cnt_r <= frame_cnt_r + 8'd1;
            if (enter_run_s) begin
              state_r <= ST_RUN;
            end
          end
        end
        ST_RUN:  state_r <= ST_RUN;
        default: state_r <= ST_MUTE;
      endcase
    end
  end

  assign tdm.bick      = bick_r;
  assign tdm.lrck      = lrck_r;
  assign tdm.sdout     = sdout_r;
  assign tdm.adc0      = adc_r[0];
  assign tdm.adc1      = adc_r[1];
  assign tdm.adc2      = adc_r[2];
  assign tdm.adc3      = adc_r[3];
  assign tdm.adc_valid = adc_valid_r;
  assign tdm.running   = running_r;

endmodule
